// File: rtl/nibble_packer_if.sv
// Valid/ready bundle between the nibble stimulus stage, the packer, and the word checker.
// The master modport drives nibbles and consumes words; the slave modport is the packer.
interface nibble_packer_if #(
   parameter int NNIB = 4
);
   localparam int W  = 4 * NNIB;
   localparam int CW = $clog2(NNIB + 1);

   logic          i_valid;
   logic          i_ready;
   logic [3:0]    i_data;
   logic          i_last;
   logic          o_valid;
   logic          o_ready;
   logic [W-1:0]  o_data;
   logic [CW-1:0] o_count;
   logic          o_xerr;

   modport master (
      output i_valid, i_data, i_last, o_ready,
      input  i_ready, o_valid, o_data, o_count, o_xerr
   );

   modport slave (
      input  i_valid, i_data, i_last, o_ready,
      output i_ready, o_valid, o_data, o_count, o_xerr
   );
endinterface

// File: rtl/nibble_packer.sv
// Packs NNIB consecutive nibbles into one word; i_last flushes a partial word.
// Optional macro PACKER_XCHK_EN enables a sticky simulation-only X/Z detect on o_xerr.
module nibble_packer #(
   parameter int NNIB      = 4,
   parameter int LSB_FIRST = 1
) (
   input logic          clk,
   input logic          rst,
   nibble_packer_if.slave bus
);
   localparam int W  = 4 * NNIB;
   localparam int CW = $clog2(NNIB + 1);

   typedef enum logic {FILL, STALL} state_t;

   state_t        r_state;
   logic [W-1:0]  r_acc;
   logic [CW-1:0] r_cnt;
   logic          r_oValid;
   logic [W-1:0]  r_oData;
   logic [CW-1:0] r_oCount;

   state_t        w_nextState;
   logic [W-1:0]  w_nextAcc;
   logic [CW-1:0] w_nextCnt;
   logic          w_load;
   logic [W-1:0]  w_loadData;
   logic          w_accept;
   logic          w_slotFree;
   logic          w_complete;
   logic [CW-1:0] w_slot;
   logic [W-1:0]  w_word;

   assign bus.i_ready = !rst && (r_state == FILL);
   assign w_accept    = bus.i_valid && bus.i_ready;
   assign w_slotFree  = !r_oValid || bus.o_ready;
   assign w_complete  = (r_cnt == CW'(NNIB - 1)) || bus.i_last;
   assign w_slot      = (LSB_FIRST != 0) ? r_cnt : (CW'(NNIB - 1) - r_cnt);
   assign w_word      = r_acc | (W'(bus.i_data) << {w_slot, 2'b00});

   // In STALL the counter keeps the index of the last nibble, so the word length is always cnt+1.
   always_comb begin
      w_nextState = r_state;
      w_nextAcc   = r_acc;
      w_nextCnt   = r_cnt;
      w_load      = 1'b0;
      w_loadData  = r_acc;
      case (r_state)
         FILL: begin
            if (w_accept) begin
               if (w_complete && w_slotFree) begin
                  w_load     = 1'b1;
                  w_loadData = w_word;
                  w_nextAcc  = '0;
                  w_nextCnt  = '0;
               end else if (w_complete) begin
                  w_nextAcc   = w_word;
                  w_nextState = STALL;
               end else begin
                  w_nextAcc = w_word;
                  w_nextCnt = r_cnt + CW'(1);
               end
            end
         end
         STALL: begin
            if (w_slotFree) begin
               w_load      = 1'b1;
               w_loadData  = r_acc;
               w_nextAcc   = '0;
               w_nextCnt   = '0;
               w_nextState = FILL;
            end
         end
         default: w_nextState = FILL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= FILL;
         r_acc   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_nextState;
         r_acc   <= w_nextAcc;
         r_cnt   <= w_nextCnt;
      end
   end

   // A load at the same edge as a handoff keeps o_valid high for back-to-back words.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_oValid <= 1'b0;
         r_oData  <= '0;
         r_oCount <= '0;
      end else if (w_load) begin
         r_oValid <= 1'b1;
         r_oData  <= w_loadData;
         r_oCount <= r_cnt + CW'(1);
      end else if (bus.o_ready) begin
         r_oValid <= 1'b0;
      end
   end

   assign bus.o_valid = r_oValid;
   assign bus.o_data  = r_oData;
   assign bus.o_count = r_oCount;

`ifdef PACKER_XCHK_EN
   logic r_xerr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_xerr <= 1'b0;
      end else if (w_accept && ((^{bus.i_data, bus.i_last}) === 1'bx)) begin
         r_xerr <= 1'b1;
      end
   end

   assign bus.o_xerr = r_xerr;
`else
   assign bus.o_xerr = 1'b0;
`endif
endmodule

// File: tb/tb_nibble_packer.sv
// Scoreboard bench for nibble_packer: two instances (LSB-first and MSB-first) share one
// stimulus stream; a queue-based reference model predicts every packed word.
module tb_nibble_packer;
   localparam int NNIB = 4;

   typedef struct {
      logic [15:0] d;
      int          c;
   } word_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       vIn;
   logic [3:0] dIn;
   logic       lIn;
   logic       oRdy;
   bit         randMode = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [3:0] pend1[$];
   logic [3:0] pend0[$];
   word_t      exp1[$];
   word_t      exp0[$];

   nibble_packer_if #(.NNIB(NNIB)) bus1 ();
   nibble_packer_if #(.NNIB(NNIB)) bus0 ();

   assign bus1.i_valid = vIn;
   assign bus1.i_data  = dIn;
   assign bus1.i_last  = lIn;
   assign bus1.o_ready = oRdy;
   assign bus0.i_valid = vIn;
   assign bus0.i_data  = dIn;
   assign bus0.i_last  = lIn;
   assign bus0.o_ready = oRdy;

   nibble_packer #(.NNIB(NNIB), .LSB_FIRST(1)) dutLsb (.clk(clk), .rst(rst), .bus(bus1));
   nibble_packer #(.NNIB(NNIB), .LSB_FIRST(0)) dutMsb (.clk(clk), .rst(rst), .bus(bus0));

   always #5 clk = ~clk;

   // Background backpressure generator used during the random phase.
   always @(posedge clk) begin
      #1;
      if (randMode) oRdy = 1'($urandom_range(0, 1));
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Reference model: collect accepted nibbles, emit a word on the NNIB-th nibble or on i_last.
   always @(negedge clk) begin
      word_t w;
      if (rst) begin
         pend1.delete();
         pend0.delete();
         exp1.delete();
         exp0.delete();
      end else begin
         if (bus1.i_valid && bus1.i_ready) begin
            pend1.push_back(bus1.i_data);
            if (pend1.size() == NNIB || bus1.i_last) begin
               w.d = '0;
               w.c = pend1.size();
               foreach (pend1[k]) w.d = w.d | (16'(pend1[k]) << (4 * k));
               exp1.push_back(w);
               pend1.delete();
            end
         end
         if (bus0.i_valid && bus0.i_ready) begin
            pend0.push_back(bus0.i_data);
            if (pend0.size() == NNIB || bus0.i_last) begin
               w.d = '0;
               w.c = pend0.size();
               foreach (pend0[k]) w.d = w.d | (16'(pend0[k]) << (4 * (NNIB - 1 - k)));
               exp0.push_back(w);
               pend0.delete();
            end
         end
      end
   end

   // Monitor: every output handoff pops and compares the oldest predicted word.
   always @(negedge clk) begin
      word_t m;
      if (!rst && bus1.o_valid && bus1.o_ready) begin
         if (exp1.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL lsb_unexpected: got word %h, expected none", bus1.o_data);
         end else begin
            m = exp1.pop_front();
            checkOutput("lsb_data", 32'(bus1.o_data), 32'(m.d));
            checkOutput("lsb_count", 32'(bus1.o_count), m.c);
         end
      end
      if (!rst && bus0.o_valid && bus0.o_ready) begin
         if (exp0.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL msb_unexpected: got word %h, expected none", bus0.o_data);
         end else begin
            m = exp0.pop_front();
            checkOutput("msb_data", 32'(bus0.o_data), 32'(m.d));
            checkOutput("msb_count", 32'(bus0.o_count), m.c);
         end
      end
   end

   // Drives one beat and holds it until accepted; returns with inputs idle and junk on data/last.
   task automatic applyStimulus(input logic [3:0] d, input logic last, output int waits);
      bit ok;
      ok    = 1'b0;
      waits = 0;
      vIn   = 1'b1;
      dIn   = d;
      lIn   = last;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         ok = bus1.i_ready;
         @(posedge clk);
         #1;
         if (ok) break;
         waits++;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: got no accept after %0d cycles, expected accept", waits);
      end
      vIn = 1'b0;
      dIn = 4'($urandom);
      lIn = 1'($urandom);
   endtask

   task automatic pulseReset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rst_ovalid", 32'(bus1.o_valid), 0);
      checkOutput("rst_odata", 32'(bus1.o_data), 0);
      checkOutput("rst_iready", 32'(bus1.i_ready), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int waits;
      int budget;
      rst  = 1'b1;
      vIn  = 1'b1;
      dIn  = 4'h5;
      lIn  = 1'b0;
      oRdy = 1'b0;

      // Reset behaviour, with i_valid held high throughout
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_ovalid", 32'(bus1.o_valid), 0);
      checkOutput("reset_odata", 32'(bus1.o_data), 0);
      checkOutput("reset_ocount", 32'(bus1.o_count), 0);
      checkOutput("reset_iready", 32'(bus1.i_ready), 0);
      checkOutput("reset_xerr", 32'(bus1.o_xerr), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      vIn = 1'b0;
      @(negedge clk);
      checkOutput("post_reset_iready", 32'(bus1.i_ready), 1);

      // Streaming at full rate: o_valid one cycle after each 4th nibble
      @(posedge clk);
      #1;
      oRdy = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(4'(k), 1'b0, waits);
         checkOutput("stream_waits", waits, 0);
         checkOutput("stream_ovalid", 32'(bus1.o_valid), (k % 4 == 0) ? 1 : 0);
      end
      repeat (2) @(posedge clk);
      #1;

      // Backpressure: second word waits in the accumulator, input stalls
      oRdy = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(4'(k), 1'b0, waits);
         checkOutput("bp_waits", waits, 0);
      end
      checkOutput("bp_iready", 32'(bus1.i_ready), 0);
      checkOutput("bp_held_lsb", 32'(bus1.o_data), 32'h4321);
      checkOutput("bp_held_msb", 32'(bus0.o_data), 32'h1234);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("bp_stable_valid", 32'(bus1.o_valid), 1);
      checkOutput("bp_stable_data", 32'(bus1.o_data), 32'h4321);
      checkOutput("bp_stable_count", 32'(bus1.o_count), 4);
      oRdy = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("bp_iready_back", 32'(bus1.i_ready), 1);

      // Flush with i_last
      applyStimulus(4'hA, 1'b0, waits);
      applyStimulus(4'hB, 1'b1, waits);
      applyStimulus(4'hC, 1'b1, waits);
      repeat (3) @(posedge clk);
      #1;

      // Reset mid-word with a held output word pending
      oRdy = 1'b0;
      for (int k = 1; k <= 7; k++) applyStimulus(4'(k), 1'b0, waits);
      pulseReset();
      oRdy = 1'b1;
      for (int k = 4; k <= 7; k++) applyStimulus(4'(k), 1'b0, waits);
      checkOutput("mid_reset_word", 32'(bus1.o_data), 32'h7654);
      repeat (2) @(posedge clk);
      #1;

      // X-detect flag
`ifdef PACKER_XCHK_EN
      applyStimulus(4'bxxxx, 1'b1, waits);
      checkOutput("xerr_set", 32'(bus1.o_xerr), 1);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("xerr_sticky", 32'(bus1.o_xerr), 1);
`else
      applyStimulus(4'h9, 1'b1, waits);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("xerr_tied", 32'(bus1.o_xerr), 0);
`endif
      pulseReset();
      checkOutput("xerr_cleared", 32'(bus1.o_xerr), 0);

      // Random stream with random backpressure, idle gaps and packet ends
      randMode = 1'b1;
      for (int n = 0; n < 300; n++) begin
         applyStimulus(4'($urandom), ($urandom_range(0, 4) == 0), waits);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      randMode = 1'b0;
      @(posedge clk);
      #1;
      oRdy = 1'b1;
      applyStimulus(4'h0, 1'b1, waits);
      budget = 0;
      while ((exp1.size() != 0 || exp0.size() != 0) && budget < 50) begin
         @(posedge clk);
         #1;
         budget++;
      end
      checkOutput("drain_lsb", exp1.size(), 0);
      checkOutput("drain_msb", exp0.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
